// File: rtl/enc_par_engine.sv
// Streaming Reed-Solomon parity engine: absorbs SYM symbols per beat and emits PAR_LEN parity symbols.
// Optional macro ENC_PAR_STAT_EN adds a saturating completed-codeword counter on port cw_count.
module enc_par_engine #(
  parameter int EGF_DIM     = 8,
  parameter int EGF_PRI_POL = 'h11D,
  parameter int PAR_LEN     = 16,
  parameter int SYM         = 4,
  parameter int MAX_MES_LEN = 239
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PAR_LEN*EGF_DIM-1:0]         gen_pol,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sop,
  input  logic [$clog2(MAX_MES_LEN+1)-1:0]   mes_len,
  input  logic [SYM*EGF_DIM-1:0]             in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic [SYM*EGF_DIM-1:0]             out_data,
  output logic                               len_err,
`ifdef ENC_PAR_STAT_EN
  output logic [15:0]                        cw_count,
`endif
  output logic [1:0]                         dbg_state
);

  localparam int LEN_W  = $clog2(MAX_MES_LEN + 1);
  localparam int PW     = PAR_LEN * EGF_DIM;
  localparam int BW     = SYM * EGF_DIM;
  localparam int N_OUT  = PAR_LEN / SYM;
  localparam int OB_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int BEAT_W = $clog2(MAX_MES_LEN / SYM + 2);
  localparam logic [EGF_DIM-1:0] POLY = EGF_DIM'(EGF_PRI_POL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  if (PAR_LEN % SYM != 0) begin : g_bad_cfg
    $error("enc_par_engine: PAR_LEN must be a multiple of SYM");
  end

  // Handshake: a beat moves on a side in any cycle where its valid and ready are both high.
  logic [1:0]        state;
  logic [PW-1:0]     par;
  logic [PW-1:0]     gen_q;
  logic [BEAT_W-1:0] beats_left;
  logic [OB_W-1:0]   out_beat;

  logic          accept, len_ok, start;
  int            rem_i, lanes, beats_i;
  logic [PW-1:0] g_use, cur, par_nxt;

  function automatic logic [EGF_DIM-1:0] gf_mul(input logic [EGF_DIM-1:0] a,
                                                input logic [EGF_DIM-1:0] b);
    logic [EGF_DIM-1:0] acc, sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < EGF_DIM; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[EGF_DIM-1] ? ({sh[EGF_DIM-2:0], 1'b0} ^ POLY) : {sh[EGF_DIM-2:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0]      p,
                                              input logic [EGF_DIM-1:0] s,
                                              input logic [PW-1:0]      g);
    logic [PW-1:0]      n;
    logic [EGF_DIM-1:0] fb;
    fb = s ^ p[PW-1 -: EGF_DIM];
    n[EGF_DIM-1:0] = gf_mul(fb, g[EGF_DIM-1:0]);
    for (int j = 1; j < PAR_LEN; j++)
      n[j*EGF_DIM +: EGF_DIM] = p[(j-1)*EGF_DIM +: EGF_DIM] ^ gf_mul(fb, g[j*EGF_DIM +: EGF_DIM]);
    return n;
  endfunction

  assign in_ready  = (state != S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign out_last  = out_valid && (out_beat == OB_W'(N_OUT - 1));
  assign out_data  = out_valid ? par[(N_OUT - 1 - int'(out_beat)) * BW +: BW] : '0;
  assign dbg_state = state;

  assign accept = in_valid && in_ready;
  assign len_ok = (mes_len != '0) && (mes_len <= LEN_W'(MAX_MES_LEN));
  assign start  = accept && in_sop && len_ok;

  // A legal SOP starts from a cleared register with the fresh generator; its partial
  // beat carries the leading rem symbols in lanes rem-1..0.
  always_comb begin
    rem_i   = int'(mes_len) % SYM;
    lanes   = (rem_i == 0) ? SYM : rem_i;
    beats_i = (int'(mes_len) + SYM - 1) / SYM;
    g_use   = start ? gen_pol : gen_q;
    cur     = start ? '0 : par;
    for (int l = SYM - 1; l >= 0; l--) begin
      if (!start || l < lanes)
        cur = lfsr_step(cur, in_data[l*EGF_DIM +: EGF_DIM], g_use);
    end
    par_nxt = cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      par        <= '0;
      gen_q      <= '0;
      beats_left <= '0;
      out_beat   <= '0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (accept && in_sop) begin
        if (len_ok) begin
          gen_q    <= gen_pol;
          par      <= par_nxt;
          out_beat <= '0;
          if (beats_i == 1) begin
            state <= S_EMIT;
          end else begin
            state      <= S_LOAD;
            beats_left <= BEAT_W'(beats_i - 1);
          end
        end else begin
          // Bad length: the beat is consumed and any message in flight is dropped.
          len_err <= 1'b1;
          state   <= S_IDLE;
        end
      end else if (accept && state == S_LOAD) begin
        par        <= par_nxt;
        beats_left <= beats_left - 1'b1;
        if (beats_left == BEAT_W'(1)) begin
          state    <= S_EMIT;
          out_beat <= '0;
        end
      end else if (state == S_EMIT && out_ready) begin
        if (out_beat == OB_W'(N_OUT - 1)) state <= S_IDLE;
        else out_beat <= out_beat + 1'b1;
      end
    end
  end

`ifdef ENC_PAR_STAT_EN
  logic [15:0] cw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cw_q <= '0;
    else if (out_valid && out_ready && out_last && cw_q != 16'hFFFF) cw_q <= cw_q + 16'd1;
  end

  assign cw_count = cw_q;
`endif

endmodule

// File: tb/tb_enc_par_engine.sv
// Directed bench for enc_par_engine: a PAR_LEN=2/SYM=2 instance for hand-computed vectors and
// a default 16/4 instance checked against a polynomial-division RS model with stalls.
module tb_enc_par_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Small instance (PAR_LEN=2, SYM=2)
  logic [15:0] s_gen_pol, s_in_data, s_out_data;
  logic [7:0]  s_mes_len;
  logic        s_in_valid, s_in_ready, s_in_sop, s_out_valid, s_out_ready, s_out_last, s_len_err;
  logic [1:0]  s_state;
  // Default instance (PAR_LEN=16, SYM=4)
  logic [127:0] l_gen_pol;
  logic [31:0]  l_in_data, l_out_data;
  logic [7:0]   l_mes_len;
  logic         l_in_valid, l_in_ready, l_in_sop, l_out_valid, l_out_ready, l_out_last, l_len_err;
  logic [1:0]   l_state;
`ifdef ENC_PAR_STAT_EN
  logic [15:0]  s_cw, l_cw;
`endif

  enc_par_engine #(.PAR_LEN(2), .SYM(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .gen_pol(s_gen_pol), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_sop(s_in_sop), .mes_len(s_mes_len), .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_last(s_out_last), .out_data(s_out_data), .len_err(s_len_err),
`ifdef ENC_PAR_STAT_EN
    .cw_count(s_cw),
`endif
    .dbg_state(s_state));

  enc_par_engine dut_l (
    .clk(clk), .rst_n(rst_n), .gen_pol(l_gen_pol), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_sop(l_in_sop), .mes_len(l_mes_len), .in_data(l_in_data), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_last(l_out_last), .out_data(l_out_data), .len_err(l_len_err),
`ifdef ENC_PAR_STAT_EN
    .cw_count(l_cw),
`endif
    .dbg_state(l_state));

  logic [7:0]  msg [256];
  logic [7:0]  gl [16];
  logic [7:0]  exp_par [16];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, r;
    x = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  // Remainder of m(x)*x^n divided by monic g(x), first message symbol = highest degree.
  task automatic model(input int len, input int n);
    logic [7:0] w [272];
    logic [7:0] c;
    for (int i = 0; i < len + n; i++) w[i] = (i < len) ? msg[i] : 8'h00;
    for (int i = 0; i < len; i++) begin
      c = w[i];
      for (int j = 1; j <= n; j++) w[i+j] = w[i+j] ^ gmul(c, gl[n-j]);
    end
    for (int t = 0; t < n; t++) exp_par[n-1-t] = w[len+t];
  endtask

  // ---------------- driver tasks: start and end just after a rising edge ----------------
  task automatic send_s(input logic sop, input logic [7:0] len, input logic [15:0] d);
    int guard = 0;
    s_in_valid = 1'b1; s_in_sop = sop; s_mes_len = len; s_in_data = d;
    forever begin
      @(negedge clk);
      if (s_in_ready) break;
      if (++guard > 50) begin timeout("s_in_accept"); break; end
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_in_sop = 1'b0;
  endtask

  task automatic recv_s(input logic [15:0] exp_d, input logic exp_last);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (s_out_valid) begin
        s_out_ready = 1'b1;
        chk("s_parity", s_out_data, exp_d);
        chk("s_last", s_out_last, exp_last);
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        break;
      end
      if (++guard > 50) begin timeout("s_out_valid"); break; end
    end
  endtask

  task automatic run_s(input int len);
    logic [15:0] d;
    int rem, nb;
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
    gl[0] = 8'h08; gl[1] = 8'h06;
    model(len, 2);
    s_gen_pol = 16'h0608;
    rem = (len % 2 == 0) ? 2 : 1;
    nb = (len + 1) / 2;
    d = 16'($urandom);
    for (int i = 0; i < rem; i++) d[(rem-1-i)*8 +: 8] = msg[i];
    send_s(1'b1, 8'(len), d);
    for (int b = 1; b < nb; b++) begin
      for (int i = 0; i < 2; i++) d[(1-i)*8 +: 8] = msg[rem + (b-1)*2 + i];
      send_s(1'b0, 8'h00, d);
    end
    recv_s({exp_par[1], exp_par[0]}, 1'b1);
  endtask

  task automatic send_l(input logic sop, input logic [7:0] len, input logic [31:0] d);
    int guard = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    l_in_valid = 1'b1; l_in_sop = sop; l_mes_len = len; l_in_data = d;
    forever begin
      @(negedge clk);
      if (l_in_ready) break;
      if (++guard > 50) begin timeout("l_in_accept"); break; end
    end
    @(posedge clk); #1;
    l_in_valid = 1'b0; l_in_sop = 1'b0;
  endtask

  task automatic recv_l(input int nb);
    int guard;
    logic [31:0] held;
    logic have;
    for (int b = 0; b < nb; b++) begin
      guard = 0;
      have = 1'b0;
      forever begin
        @(negedge clk);
        if (l_out_valid) begin
          chk("l_in_ready_emit", l_in_ready, 1'b0);
          if (have) chk("l_hold", l_out_data, held);
          held = l_out_data;
          have = 1'b1;
          if ($urandom_range(0, 3) != 0) begin
            l_out_ready = 1'b1;
            chk("l_parity", l_out_data, exp_q.pop_front());
            chk("l_last", l_out_last, b == nb - 1);
            @(posedge clk); #1;
            l_out_ready = 1'b0;
            break;
          end
        end
        if (++guard > 100) begin timeout("l_out_valid"); break; end
      end
    end
  endtask

  task automatic run_l(input int len);
    logic [31:0] d;
    int rem, nb;
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
    for (int j = 0; j < 16; j++) begin
      gl[j] = 8'($urandom_range(0, 255));
      l_gen_pol[j*8 +: 8] = gl[j];
    end
    model(len, 16);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({exp_par[15-4*k], exp_par[14-4*k], exp_par[13-4*k], exp_par[12-4*k]});
    rem = (len % 4 == 0) ? 4 : len % 4;
    nb = (len + 3) / 4;
    d = $urandom;
    for (int i = 0; i < rem; i++) d[(rem-1-i)*8 +: 8] = msg[i];
    send_l(1'b1, 8'(len), d);
    l_gen_pol = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 1; b < nb; b++) begin
      for (int i = 0; i < 4; i++) d[(3-i)*8 +: 8] = msg[rem + (b-1)*4 + i];
      send_l(1'b0, 8'h00, d);
    end
    recv_l(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_gen_pol = '0; s_in_valid = 0; s_in_sop = 0; s_mes_len = '0; s_in_data = '0; s_out_ready = 0;
    l_gen_pol = '0; l_in_valid = 0; l_in_sop = 0; l_mes_len = '0; l_in_data = '0; l_out_ready = 0;

    // Reset values
    #12;
    chk("rst_in_ready", s_in_ready, 1'b1);
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_out_last", s_out_last, 1'b0);
    chk("rst_out_data", l_out_data, 32'h0);
    chk("rst_len_err", s_len_err, 1'b0);
    chk("rst_state", l_state, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single symbol, upper lane ignored
    s_gen_pol = 16'h0608;
    send_s(1'b1, 8'd1, 16'hAA01);
    @(negedge clk);
    chk("s1_valid_next_cycle", s_out_valid, 1'b1);
    chk("s1_in_ready_emit", s_in_ready, 1'b0);
    recv_s(16'h0608, 1'b1);
    @(negedge clk);
    chk("s1_idle_valid", s_out_valid, 1'b0);
    chk("s1_idle_ready", s_in_ready, 1'b1);
    @(posedge clk); #1;

    // Two symbols in one beat
    send_s(1'b1, 8'd2, 16'h0100);
    @(negedge clk);
    chk("s2_valid_next_cycle", s_out_valid, 1'b1);
    recv_s(16'h1C30, 1'b1);

    // Multi-beat messages with a partial leading beat
    run_s(3);
    run_s(6);

    // Illegal lengths in IDLE
    send_s(1'b1, 8'd0, 16'h1234);
    @(negedge clk);
    chk("len0_err", s_len_err, 1'b1);
    @(negedge clk);
    chk("len0_err_pulse", s_len_err, 1'b0);
    chk("len0_no_valid", s_out_valid, 1'b0);
    @(posedge clk); #1;
    send_s(1'b1, 8'd255, 16'h1234);
    @(negedge clk);
    chk("len255_err", s_len_err, 1'b1);
    @(negedge clk);
    chk("len255_err_pulse", s_len_err, 1'b0);
    chk("len255_no_valid", s_out_valid, 1'b0);
    chk("len255_state", s_state, 2'd0);
    @(posedge clk); #1;

    // Legal SOP mid-LOAD restarts the message
    send_s(1'b1, 8'd5, 16'h0011);
    send_s(1'b0, 8'd0, 16'h2233);
    run_s(4);

    // Illegal SOP mid-LOAD drops to IDLE; the next plain beat is discarded
    send_s(1'b1, 8'd4, 16'h4455);
    send_s(1'b1, 8'd0, 16'h6677);
    @(negedge clk);
    chk("load_bad_err", s_len_err, 1'b1);
    @(posedge clk); #1;
    send_s(1'b0, 8'd0, 16'h8899);
    @(negedge clk);
    chk("load_bad_no_valid", s_out_valid, 1'b0);
    chk("load_bad_state", s_state, 2'd0);
    @(posedge clk); #1;
    run_s(1);

    // Default instance: boundary and random lengths with stalls on both sides
    run_l(1);
    run_l(4);
    run_l(5);
    run_l(239);
    for (int i = 0; i < 3; i++) run_l($urandom_range(2, 238));

    // Reset during emission
    l_gen_pol = {4{32'h1F2E3D4C}};
    send_l(1'b1, 8'd3, 32'h00010203);
    begin
      int guard = 0;
      forever begin
        @(negedge clk);
        if (l_out_valid) break;
        if (++guard > 20) begin timeout("l_rst_emit"); break; end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_emit_valid", l_out_valid, 1'b0);
    chk("rst_emit_ready", l_in_ready, 1'b1);
    chk("rst_emit_data", l_out_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_l(7);
    chk("l_queue_drained", exp_q.size(), 0);

`ifdef ENC_PAR_STAT_EN
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("stat_rst", s_cw, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_s(2); run_s(3); run_s(1);
    send_s(1'b1, 8'd0, 16'h0);
    @(negedge clk);
    chk("stat_three", s_cw, 16'd3);
    force dut_s.cw_q = 16'hFFFF;
    #1 release dut_s.cw_q;
    @(posedge clk); #1;
    run_s(2);
    @(negedge clk);
    chk("stat_saturate", s_cw, 16'hFFFF);
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
